// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared state encodings and constants for the IF fetch controller
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IF_REQ   = 2'd0,
        IF_WAIT  = 2'd1,
        IF_HOLD  = 2'd2,
        IF_DRAIN = 2'd3
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam logic [1:0]  SIZE_WORD        = 2'd2;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - IF stage bus: SRAM-like fetch port plus ID handshake (optional IF_ADEL_EN)
interface if_fetch_ctrl_if;

    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        id_allowin;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] cur_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
`ifdef IF_ADEL_EN
    logic        if_adel;
`endif

    modport master (
        input  next_pc, flush, flush_pc, id_allowin,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
`ifdef IF_ADEL_EN
        output if_adel,
`endif
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output cur_pc, if_valid, if_pc, if_inst
    );

    modport slave (
        output next_pc, flush, flush_pc, id_allowin,
        output inst_addr_ok, inst_data_ok, inst_rdata,
`ifdef IF_ADEL_EN
        input  if_adel,
`endif
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  cur_pc, if_valid, if_pc, if_inst
    );

endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage PC register and single-outstanding fetch FSM (optional IF_ADEL_EN)
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    if_fetch_ctrl_if.master  bus
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        inst_req_q, inst_req_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        cancel_q, cancel_d;
    logic        redirect_q, redirect_d;
`ifdef IF_ADEL_EN
    logic        adel_q, adel_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IF_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            inst_req_q <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            cancel_q   <= 1'b0;
            redirect_q <= 1'b0;
`ifdef IF_ADEL_EN
            adel_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inst_req_q <= inst_req_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            cancel_q   <= cancel_d;
            redirect_q <= redirect_d;
`ifdef IF_ADEL_EN
            adel_q     <= adel_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        cancel_d   = cancel_q;
        redirect_d = redirect_q;
`ifdef IF_ADEL_EN
        adel_d     = adel_q;
`endif

        case (state_q)
            IF_REQ: begin
                if (bus.flush) pc_d = bus.flush_pc;
                // inst_req_q is low only in the first cycle out of reset; nothing is on the bus yet
                if (inst_req_q) begin
                    if (bus.flush) begin
                        cancel_d   = 1'b1;
                        redirect_d = 1'b1;
                        state_d    = bus.inst_addr_ok ? IF_WAIT : IF_DRAIN;
                    end else if (bus.inst_addr_ok) begin
                        redirect_d = 1'b0;
                        state_d    = IF_WAIT;
                    end
                end
            end
            IF_DRAIN: begin
                // A cancelled request still has to be accepted before it can be retired
                if (bus.flush) pc_d = bus.flush_pc;
                if (bus.inst_addr_ok) state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if (bus.flush) begin
                    pc_d       = bus.flush_pc;
                    cancel_d   = 1'b1;
                    redirect_d = 1'b1;
                end
                if (bus.inst_data_ok) begin
                    if (bus.flush || cancel_q) begin
                        cancel_d = 1'b0;
                        state_d  = IF_REQ;
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_inst_d  = bus.inst_rdata;
                        state_d    = IF_HOLD;
                    end
                end
            end
            IF_HOLD: begin
                if (bus.flush) begin
                    pc_d       = bus.flush_pc;
                    if_valid_d = 1'b0;
                    redirect_d = 1'b1;
                    state_d    = IF_REQ;
                end else if (bus.id_allowin) begin
                    pc_d       = bus.next_pc;
                    if_valid_d = 1'b0;
                    state_d    = IF_REQ;
                end
            end
            default: state_d = IF_REQ;
        endcase

`ifdef IF_ADEL_EN
        if (state_d != IF_HOLD) adel_d = 1'b0;
        // Misaligned PC never reaches the bus; it is presented to ID as a faulting slot
        if (state_d == IF_REQ && state_q != IF_REQ && pc_d[1:0] != 2'b00) begin
            state_d    = IF_HOLD;
            if_valid_d = 1'b1;
            adel_d     = 1'b1;
            if_inst_d  = '0;
            if_pc_d    = pc_d;
        end
`endif

        inst_req_d = (state_d == IF_REQ) || (state_d == IF_DRAIN);
        req_addr_d = (state_d == IF_REQ) ? pc_d : req_addr_q;
    end

    assign bus.inst_req   = inst_req_q;
    assign bus.inst_wr    = 1'b0;
    assign bus.inst_size  = SIZE_WORD;
    assign bus.inst_addr  = req_addr_q;
    assign bus.inst_wdata = '0;
    assign bus.cur_pc     = pc_q;
    assign bus.if_valid   = if_valid_q;
    assign bus.if_pc      = if_pc_q;
    assign bus.if_inst    = if_inst_q;
`ifdef IF_ADEL_EN
    assign bus.if_adel    = adel_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed scoreboard bench for if_fetch_ctrl (optional IF_ADEL_EN)
module tb_if_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    if_fetch_ctrl_if bus();

    if_fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic fetch_ok(input logic [31:0] rd, input logic [31:0] pc);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = rd;
        push_exp(pc, rd);
        tick();
        bus.inst_data_ok = 1'b0;
        chk("fetch_valid", bus.if_valid, 1);
    endtask

    task automatic accept(input logic [31:0] npc);
        bus.id_allowin = 1'b1;
        bus.next_pc    = npc;
        tick();
        bus.id_allowin = 1'b0;
        chk("accept_req", bus.inst_req, 1);
        chk("accept_addr", bus.inst_addr, npc);
        chk("accept_valid_drop", bus.if_valid, 0);
    endtask

    // Scoreboard monitor: pops on every accepted presentation to ID
    always @(negedge clk) begin
        if (!reset && bus.if_valid && bus.id_allowin && !bus.flush) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_delivery: got pc %h inst %h, required no delivery", bus.if_pc, bus.if_inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("deliver_pc", bus.if_pc, e.pc);
                chk("deliver_inst", bus.if_inst, e.inst);
            end
        end
    end

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b1;
        bus.next_pc      = '0;
        bus.flush        = 1'b0;
        bus.flush_pc     = '0;
        bus.id_allowin   = 1'b0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        tick();
        tick();

        chk("rst_req", bus.inst_req, 0);
        chk("rst_valid", bus.if_valid, 0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_inst", bus.if_inst, 32'h0);
        chk("rst_cur_pc", bus.cur_pc, 32'hbfc00000);
        chk("const_wr", bus.inst_wr, 0);
        chk("const_size", bus.inst_size, 2);
        chk("const_wdata", bus.inst_wdata, 32'h0);

        reset = 1'b0;
        tick();
        chk("first_req", bus.inst_req, 1);
        chk("first_addr", bus.inst_addr, 32'hbfc00000);

        // Minimum latency fetch, then backpressure
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        chk("wait_no_req", bus.inst_req, 0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h24020001;
        push_exp(32'hbfc00000, 32'h24020001);
        tick();
        bus.inst_data_ok = 1'b0;
        chk("t1_valid", bus.if_valid, 1);
        chk("t1_pc", bus.if_pc, 32'hbfc00000);
        chk("t1_inst", bus.if_inst, 32'h24020001);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_no_req", bus.inst_req, 0);
            chk("bp_valid", bus.if_valid, 1);
            chk("bp_inst", bus.if_inst, 32'h24020001);
        end
        accept(32'hbfc00004);

        // addr_ok delayed 4 cycles (stray data_ok in REQ ignored), data_ok 3 after
        for (int i = 0; i < 4; i++) begin
            bus.inst_data_ok = (i == 0);
            bus.inst_rdata   = 32'hbad0bad0;
            tick();
            bus.inst_data_ok = 1'b0;
            chk("dly_req", bus.inst_req, 1);
            chk("dly_addr", bus.inst_addr, 32'hbfc00004);
            chk("dly_valid", bus.if_valid, 0);
        end
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dly_wait_valid", bus.if_valid, 0);
            chk("dly_wait_req", bus.inst_req, 0);
        end
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h8c010004;
        push_exp(32'hbfc00004, 32'h8c010004);
        tick();
        bus.inst_data_ok = 1'b0;
        chk("dly_valid_set", bus.if_valid, 1);
        accept(32'hbfc00008);

        // Flush in WAIT: returned data dropped, refetch at flush_pc
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.flush        = 1'b1;
        bus.flush_pc     = 32'hbfc00380;
        tick();
        bus.flush = 1'b0;
        chk("fw_cur_pc", bus.cur_pc, 32'hbfc00380);
        chk("fw_no_req", bus.inst_req, 0);
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hdeadbeef;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("fw_drop_valid", bus.if_valid, 0);
        chk("fw_req", bus.inst_req, 1);
        chk("fw_addr", bus.inst_addr, 32'hbfc00380);
        fetch_ok(32'h3c1a0000, 32'hbfc00380);
        accept(32'hbfc00384);

        // Flush in REQ before addr_ok: address held, data dropped
        tick();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'hbfc00400;
        tick();
        bus.flush = 1'b0;
        chk("fr_req", bus.inst_req, 1);
        chk("fr_addr_held", bus.inst_addr, 32'hbfc00384);
        chk("fr_cur_pc", bus.cur_pc, 32'hbfc00400);
        tick();
        chk("fr_addr_held2", bus.inst_addr, 32'hbfc00384);
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        chk("fr_wait_no_req", bus.inst_req, 0);
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h11111111;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("fr_drop_valid", bus.if_valid, 0);
        chk("fr_req_new", bus.inst_req, 1);
        chk("fr_addr_new", bus.inst_addr, 32'hbfc00400);

        // Flush coincident with data_ok
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h22222222;
        bus.flush        = 1'b1;
        bus.flush_pc     = 32'hbfc00500;
        tick();
        bus.inst_data_ok = 1'b0;
        bus.flush        = 1'b0;
        chk("fd_drop_valid", bus.if_valid, 0);
        chk("fd_req", bus.inst_req, 1);
        chk("fd_addr", bus.inst_addr, 32'hbfc00500);

        // Flush in HOLD overrides id_allowin
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h33333333;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("fh_valid", bus.if_valid, 1);
        chk("fh_pc", bus.if_pc, 32'hbfc00500);
        chk("fh_inst", bus.if_inst, 32'h33333333);
        bus.flush      = 1'b1;
        bus.flush_pc   = 32'hbfc00600;
        bus.id_allowin = 1'b1;
        bus.next_pc    = 32'hbfc00504;
        tick();
        bus.flush      = 1'b0;
        bus.id_allowin = 1'b0;
        chk("fh_valid_drop", bus.if_valid, 0);
        chk("fh_req", bus.inst_req, 1);
        chk("fh_addr", bus.inst_addr, 32'hbfc00600);
        fetch_ok(32'h44444444, 32'hbfc00600);

`ifdef IF_ADEL_EN
        bus.id_allowin = 1'b1;
        bus.next_pc    = 32'hbfc00002;
        tick();
        bus.id_allowin = 1'b0;
        chk("adel_no_req", bus.inst_req, 0);
        chk("adel_valid", bus.if_valid, 1);
        chk("adel_flag", bus.if_adel, 1);
        chk("adel_inst", bus.if_inst, 32'h0);
        chk("adel_pc", bus.if_pc, 32'hbfc00002);
        push_exp(32'hbfc00002, 32'h0);
        accept(32'hbfc00008);
        chk("adel_clear", bus.if_adel, 0);
`else
        accept(32'hbfc00604);
`endif

        // Reset mid-transaction, stray data_ok afterwards ignored
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        reset = 1'b1;
        #1;
        chk("mrst_req", bus.inst_req, 0);
        chk("mrst_valid", bus.if_valid, 0);
        chk("mrst_cur_pc", bus.cur_pc, 32'hbfc00000);
        chk("mrst_addr", bus.inst_addr, 32'hbfc00000);
        tick();
        reset            = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h55555555;
        tick();
        bus.inst_data_ok = 1'b0;
        chk("mrst_stray_valid", bus.if_valid, 0);
        chk("mrst_req_after", bus.inst_req, 1);
        chk("mrst_addr_after", bus.inst_addr, 32'hbfc00000);
        fetch_ok(32'h66666666, 32'hbfc00000);
        accept(32'hbfc00004);

        tick();
        tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
